piso_serialiser: RTL and testbench
==================================

Name: piso_serialiser

Overview:
Parallel-in serial-out shift register; the transmit-side counterpart to the team's serial-in parallel-out DFF chain.
- Accepts a WIDTH-bit word via a valid/ready load handshake.
- Emits the word one bit per CLK on SER_OUT, with a frame-valid qualifier and start/last markers.
- Supports back-to-back frames with no idle gap, so the downstream SIPO captures a continuous bit stream.

Parameters:
WIDTH, 8, word length in bits (>= 2)
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first

Ports:
CLK  input  1  system clock; all state updates on rising edge
N_RESET  input  1  reset, asynchronous, active-high
DATA_IN  input  WIDTH  parallel word to transmit
LOAD_VALID  input  1  DATA_IN holds a word to send
LOAD_READY  output  1  block accepts DATA_IN this cycle
SER_OUT  output  1  serial data bit
SER_VALID  output  1  SER_OUT carries a frame bit
FRAME_START  output  1  high during the first bit of a frame
FRAME_LAST  output  1  high during the last bit of a frame

Behaviour:
- State: enum {IDLE, SHIFT}; shift register shreg[WIDTH-1:0]; bit counter bit_cnt[$clog2(WIDTH)-1:0].
- Reset (N_RESET=1, async): state=IDLE, shreg=0, bit_cnt=0. Resulting outputs: SER_OUT=0, SER_VALID=0, FRAME_START=0, FRAME_LAST=0, LOAD_READY=1. LOAD_VALID is ignored while reset is asserted.
- All outputs decode from registers only; there is no combinational path from DATA_IN or LOAD_VALID to any output.
- LOAD_READY = (state==IDLE) || (state==SHIFT && bit_cnt==WIDTH-1).
- accept = LOAD_VALID && LOAD_READY. On accept: shreg<=DATA_IN, bit_cnt<=0, state<=SHIFT.
- Latency: the first bit appears on SER_OUT in the cycle after the accepting edge.
- SHIFT:
  - SER_VALID=1.
  - SER_OUT = MSB_FIRST ? shreg[WIDTH-1] : shreg[0].
  - Each edge: shreg shifts by one toward the output end with 0 filled in, and bit_cnt increments.
- FRAME_START = (state==SHIFT && bit_cnt==0).
- FRAME_LAST = (state==SHIFT && bit_cnt==WIDTH-1).
- At bit_cnt==WIDTH-1:
  - accept: reload and stay in SHIFT, giving a back-to-back frame with zero gap.
  - no accept: state<=IDLE, bit_cnt<=0.
- A frame occupies exactly WIDTH consecutive SER_VALID cycles and is never truncated or stretched by LOAD_VALID activity.
- LOAD_VALID asserted while LOAD_READY=0 has no effect. DATA_IN changes mid-frame do not alter the bits in flight.
- IDLE: SER_OUT=0, SER_VALID=0.
- Reset mid-frame: the frame is aborted immediately (async). SER_VALID drops in the same cycle. The first edge after release with LOAD_VALID=1 starts a new frame.
- The counter must not wrap past WIDTH-1. The WIDTH-1 compare must work for non-power-of-2 WIDTH.

Decomposition:
- Package piso_pkg: state enum type piso_state_t {IDLE, SHIFT}; function for counter width, clog2(WIDTH) with a minimum of 1.
- One natural sub-module, piso_bit_counter:
  - Inputs: clear, enable.
  - Outputs: count, terminal (count==WIDTH-1).
  - Async active-high reset on N_RESET.
- Shift register and FSM stay in the top module.

Test Plan:
1. MSB_FIRST=1: reset, then load 8'b10101101 with a one-cycle LOAD_VALID pulse.
   -> SER_OUT = 1,0,1,0,1,1,0,1 over the next 8 cycles with SER_VALID=1.
   -> FRAME_START in cycle 1, FRAME_LAST in cycle 8.
   -> Cycle 9: IDLE, SER_VALID=0, LOAD_READY=1.
2. MSB_FIRST=0: load 8'b10101101.
   -> SER_OUT = 1,0,1,1,0,1,0,1; the same framing markers as scenario 1.
3. Back-to-back: hold LOAD_VALID=1 with 8'hAD, then switch DATA_IN to 8'h3C when LOAD_READY rises during FRAME_LAST.
   -> 16 contiguous SER_VALID cycles carrying 10101101 then 00111100.
   -> FRAME_START on cycles 1 and 9.
4. Busy rejection: load 8'hAD; on cycles 2-7 drive LOAD_VALID=1 with DATA_IN=8'hFF.
   -> LOAD_READY=0 on cycles 1-7; the serial stream is still 10101101.
   -> 8'hFF is accepted at cycle 8 (LOAD_READY=1) and follows with no gap.
5. Reset mid-frame: assert N_RESET during bit 4 of 8'hAD.
   -> SER_OUT=0, SER_VALID=0 immediately.
   -> After release, loading 8'h5A gives a full 01011010 frame.
6. Loopback: drive SER_OUT into the team's 8-bit SIPO DFF chain, clocked on the same edge and enabled by SER_VALID.
   -> After 8 bits of 8'hAD (MSB_FIRST=1), the SIPO parallel output reads 8'b10101101.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out serialiser.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    // Bit-counter width: enough to hold WIDTH-1, never narrower than one bit.
    function automatic int cnt_w(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit counter: counts 0..WIDTH-1 and flags the terminal (last) bit.
// Latency: count updates on the edge after clear/enable; terminal decodes from the register.
// Backpressure: none; holds at WIDTH-1 rather than wrapping if left enabled.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input  logic             CLK,
    input  logic             N_RESET,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Equality against WIDTH-1 so non-power-of-2 widths end on the right bit.
    assign terminal = (count_q == LAST_CNT);
    assign count    = count_q;

    // Next count: clear wins, otherwise step until the terminal value.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !terminal) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register, asynchronously cleared.
    always_ff @(posedge CLK or posedge N_RESET) begin
        if (N_RESET) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/piso_serialiser.sv
// Parallel-in serial-out shifter: loads a WIDTH-bit word and emits one bit per CLK with framing markers.
// Latency: first bit on SER_OUT the cycle after the accepting edge; frames can run back-to-back with no gap.
// Backpressure: LOAD_READY is high only when idle or on the last bit of the current frame.
module piso_serialiser
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             N_RESET,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    output logic             SER_OUT,
    output logic             SER_VALID,
    output logic             FRAME_START,
    output logic             FRAME_LAST
);

    localparam int CNT_W = cnt_w(WIDTH);

    piso_state_t      state_q;
    piso_state_t      state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    logic [CNT_W-1:0] bit_cnt;
    logic             bit_last;
    logic             in_shift;
    logic             accept;
    logic             cnt_clear;

    assign in_shift = (state_q == SHIFT);

    // Ready depends only on registered state, so LOAD_VALID never reaches an output combinationally.
    assign LOAD_READY = !in_shift || bit_last;
    assign accept     = LOAD_VALID && LOAD_READY;

    // Counter restarts on every load and also on a frame end that returns to idle.
    assign cnt_clear = accept || (in_shift && bit_last);

    piso_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .CLK      (CLK),
        .N_RESET  (N_RESET),
        .clear    (cnt_clear),
        .enable   (in_shift),
        .count    (bit_cnt),
        .terminal (bit_last)
    );

    // Next state: enter SHIFT on a load, leave only at the last bit when nothing new is accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_last) begin
                    state_d = accept ? SHIFT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shift register: load on accept, otherwise move one place toward the output end, zero-filled.
    always_comb begin
        shreg_d = shreg_q;
        if (accept) begin
            shreg_d = DATA_IN;
        end else if (in_shift) begin
            if (MSB_FIRST) begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end
        end
    end

    // State and data registers; reset aborts any frame in flight.
    always_ff @(posedge CLK or posedge N_RESET) begin
        if (N_RESET) begin
            state_q <= IDLE;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
        end
    end

    // Outputs decode from registers only; SER_OUT is forced low outside a frame.
    assign SER_VALID   = in_shift;
    assign SER_OUT     = in_shift && (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
    assign FRAME_START = in_shift && (bit_cnt == '0);
    assign FRAME_LAST  = in_shift && bit_last;

endmodule

// File: tb/tb_piso_serialiser.sv
// Bench for piso_serialiser: MSB-first and LSB-first instances driven in parallel, each with a SIPO loopback.
// Latency: expected frames are queued at the accepting edge and popped by the monitor on every SER_VALID bit.
// Backpressure: LOAD_READY is checked cycle by cycle against hand-derived values.
module tb_piso_serialiser;

    logic       CLK;
    logic       N_RESET;
    logic [7:0] data_in;
    logic       load_valid;

    logic m_rdy, m_ser, m_vld, m_st, m_la;
    logic l_rdy, l_ser, l_vld, l_st, l_la;

    logic [7:0] sipo_m;
    logic [7:0] sipo_l;

    typedef struct packed {
        logic b;
        logic st;
        logic la;
        logic cg;
    } exp_t;

    exp_t q_msb[$];
    exp_t q_lsb[$];

    int n_total = 0;
    int n_pass  = 0;
    logic prev_m = 1'b0;
    logic prev_l = 1'b0;

    piso_serialiser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .CLK         (CLK),
        .N_RESET     (N_RESET),
        .DATA_IN     (data_in),
        .LOAD_VALID  (load_valid),
        .LOAD_READY  (m_rdy),
        .SER_OUT     (m_ser),
        .SER_VALID   (m_vld),
        .FRAME_START (m_st),
        .FRAME_LAST  (m_la)
    );

    piso_serialiser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .CLK         (CLK),
        .N_RESET     (N_RESET),
        .DATA_IN     (data_in),
        .LOAD_VALID  (load_valid),
        .LOAD_READY  (l_rdy),
        .SER_OUT     (l_ser),
        .SER_VALID   (l_vld),
        .FRAME_START (l_st),
        .FRAME_LAST  (l_la)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Receive-side SIPO chains on the same edge, enabled by SER_VALID.
    always @(posedge CLK or posedge N_RESET) begin
        if (N_RESET) begin
            sipo_m <= 8'h00;
            sipo_l <= 8'h00;
        end else begin
            if (m_vld) sipo_m <= {sipo_m[6:0], m_ser};
            if (l_vld) sipo_l <= {l_ser, sipo_l[7:1]};
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic fail(input string name);
        n_total++;
        $display("FAIL %s: got unexpected serial bit, expected none", name);
    endtask

    // Queue one frame per instance; cg=1 means the previous cycle must also have been valid.
    task automatic push(input logic [7:0] w, input bit b2b);
        for (int i = 0; i < 8; i++) begin
            q_msb.push_back(exp_t'{w[7-i], (i == 0), (i == 7), ((i != 0) || b2b)});
            q_lsb.push_back(exp_t'{w[i],   (i == 0), (i == 7), ((i != 0) || b2b)});
        end
    endtask

    task automatic mon(input bit which, input logic vld, input logic ser, input logic st,
                       input logic la, input logic prev);
        exp_t  e;
        string t;
        if (!vld) return;
        t = which ? "lsb" : "msb";
        if (which == 1'b0) begin
            if (q_msb.size() == 0) begin fail({t, " extra_bit"}); return; end
            e = q_msb.pop_front();
        end else begin
            if (q_lsb.size() == 0) begin fail({t, " extra_bit"}); return; end
            e = q_lsb.pop_front();
        end
        check({t, " ser_out"},     {31'd0, ser}, {31'd0, e.b});
        check({t, " frame_start"}, {31'd0, st},  {31'd0, e.st});
        check({t, " frame_last"},  {31'd0, la},  {31'd0, e.la});
        if (e.cg) check({t, " no_gap"}, {31'd0, prev}, 32'd1);
    endtask

    // Monitor: away from the active edge, pop and compare every presented bit.
    always @(negedge CLK) begin
        if (N_RESET) begin
            prev_m = 1'b0;
            prev_l = 1'b0;
        end else begin
            mon(1'b0, m_vld, m_ser, m_st, m_la, prev_m);
            mon(1'b1, l_vld, l_ser, l_st, l_la, prev_l);
            prev_m = m_vld;
            prev_l = l_vld;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_ready(input string name, input logic exp);
        check({name, " msb_ready"}, {31'd0, m_rdy}, {31'd0, exp});
        check({name, " lsb_ready"}, {31'd0, l_rdy}, {31'd0, exp});
    endtask

    task automatic check_idle(input string name);
        check({name, " msb_vld"}, {31'd0, m_vld}, 32'd0);
        check({name, " lsb_vld"}, {31'd0, l_vld}, 32'd0);
        check({name, " msb_ser"}, {31'd0, m_ser}, 32'd0);
        check({name, " lsb_ser"}, {31'd0, l_ser}, 32'd0);
        check_ready(name, 1'b1);
    endtask

    initial begin
        // Reset with LOAD_VALID asserted: it must be ignored.
        N_RESET    = 1'b1;
        load_valid = 1'b1;
        data_in    = 8'hFF;
        repeat (3) @(posedge CLK);
        #1;
        check_idle("reset");
        check("reset msb_start", {31'd0, m_st}, 32'd0);
        check("reset msb_last",  {31'd0, m_la}, 32'd0);
        load_valid = 1'b0;
        #2 N_RESET = 1'b0;
        step();

        // Single frame of 8'hAD: ready low for bits 1-7, high on bit 8, idle after.
        data_in    = 8'hAD;
        load_valid = 1'b1;
        step();
        push(8'hAD, 1'b0);
        load_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check_ready($sformatf("single c%0d", c), (c == 8));
            step();
        end
        check_idle("single c9");
        check("loop msb sipo", {24'd0, sipo_m}, 32'h000000AD);
        check("loop lsb sipo", {24'd0, sipo_l}, 32'h000000AD);
        step();

        // Back-to-back: LOAD_VALID held, data switched to 8'h3C when ready rises.
        data_in    = 8'hAD;
        load_valid = 1'b1;
        step();
        push(8'hAD, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            check_ready($sformatf("b2b c%0d", c), 1'b0);
            step();
        end
        check_ready("b2b c8", 1'b1);
        data_in = 8'h3C;
        step();
        push(8'h3C, 1'b1);
        load_valid = 1'b0;
        repeat (8) step();
        check_idle("b2b end");
        check("b2b msb sipo", {24'd0, sipo_m}, 32'h0000003C);
        step();

        // Busy rejection: 8'hFF offered on bits 2-7 is ignored, accepted on bit 8.
        data_in    = 8'hAD;
        load_valid = 1'b1;
        step();
        push(8'hAD, 1'b0);
        load_valid = 1'b0;
        check_ready("busy c1", 1'b0);
        step();
        for (int c = 2; c <= 7; c++) begin
            load_valid = 1'b1;
            data_in    = 8'hFF;
            check_ready($sformatf("busy c%0d", c), 1'b0);
            step();
        end
        check_ready("busy c8", 1'b1);
        step();
        push(8'hFF, 1'b1);
        load_valid = 1'b0;
        repeat (8) step();
        check_idle("busy end");
        check("busy msb sipo", {24'd0, sipo_m}, 32'h000000FF);
        step();

        // Reset during bit 4 aborts the frame at once; a fresh 8'h5A follows release.
        data_in    = 8'hAD;
        load_valid = 1'b1;
        step();
        push(8'hAD, 1'b0);
        load_valid = 1'b0;
        repeat (3) step();
        @(negedge CLK);
        #2 N_RESET = 1'b1;
        #1;
        check_idle("abort");
        check("abort bits_left", q_msb.size(), 32'd4);
        q_msb.delete();
        q_lsb.delete();
        data_in    = 8'h5A;
        load_valid = 1'b1;
        step();
        step();
        check("abort held msb_vld", {31'd0, m_vld}, 32'd0);
        #2 N_RESET = 1'b0;
        step();
        push(8'h5A, 1'b0);
        load_valid = 1'b0;
        repeat (8) step();
        check_idle("restart end");
        check("restart msb sipo", {24'd0, sipo_m}, 32'h0000005A);
        check("restart lsb sipo", {24'd0, sipo_l}, 32'h0000005A);

        repeat (2) step();
        check("msb queue drained", q_msb.size(), 32'd0);
        check("lsb queue drained", q_lsb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
